// File: rtl/i2c_codec_responder_pkg.sv
// Shared definitions for the I2C codec control-port responder: FSM encoding,
// default device address and the special shadow-register indices.
package i2c_codec_responder_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_A,
    S_BYTE1,
    S_ACK1,
    S_BYTE2,
    S_ACK2,
    S_WAIT_STOP,
    S_IGNORE
  } state_t;

  localparam logic [7:0] DEV_ADDR_DEF = 8'h34;
  localparam logic [6:0] RESET_IDX    = 7'h0F;
  localparam logic [6:0] ACTIVE_IDX   = 7'd9;

endpackage

// File: rtl/i2c_codec_responder_if.sv
// Bus pins and register-write side of the codec responder. The slave modport
// is the responder; the master modport is the initiator / register consumer.
interface i2c_codec_responder_if;
  logic       I2C_SCLK;
  logic       I2C_SDAT_IN;
  logic       I2C_SDAT_OE;
  logic       REG_WE;
  logic [6:0] REG_ADDR;
  logic [8:0] REG_DATA;
  logic       ACTIVE;
  logic       ERR;
  logic       BUSY;

  modport slave (
    input  I2C_SCLK, I2C_SDAT_IN,
    output I2C_SDAT_OE, REG_WE, REG_ADDR, REG_DATA, ACTIVE, ERR, BUSY
  );

  modport master (
    output I2C_SCLK, I2C_SDAT_IN,
    input  I2C_SDAT_OE, REG_WE, REG_ADDR, REG_DATA, ACTIVE, ERR, BUSY
  );
endinterface

// File: rtl/i2c_codec_responder_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus a history flop; derives SCL edges
// and START/STOP conditions from the synchronized samples only.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [0] metastability flop, [1] synchronized value, [2] previous value
  logic [2:0] scl_q, sda_q;
  logic       scl_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  assign scl      = scl_q[1];
  assign sda      = sda_q[1];
  assign scl_hi   = scl_q[1] & scl_q[2];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_hi & sda_q[2] & ~sda_q[1];
  assign stop     = scl_hi & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_codec_responder.sv
// Write-only I2C responder for a codec control port: 3-byte writes
// (device, {idx,d8}, d[7:0]) update a small shadow register file.
module i2c_codec_responder
  import i2c_codec_responder_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR = DEV_ADDR_DEF,
  parameter int         NREG     = 12
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  i2c_codec_responder_if.slave   bus
);

  logic scl, sda, scl_rise, scl_fall, start, stop;

  i2c_bus_sync u_sync (
    .clk      (CLOCK),
    .rst_n    (RESET),
    .scl_in   (bus.I2C_SCLK),
    .sda_in   (bus.I2C_SDAT_IN),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t     state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       full, full_n;      // 8 bits captured, waiting for the SCL fall
  logic       skip, skip_n;      // swallow the 9th clock of a NACKed byte
  logic [7:0] byte1, byte1_n;
  logic       oe, oe_n;
  logic       busy, busy_n;
  logic       we, we_n;
  logic       err, err_n;
  logic [6:0] reg_addr, reg_addr_n;
  logic [8:0] reg_data, reg_data_n;
  logic       clr_q;
  logic [6:0] idx;
  logic       idx_ok;
  logic [8:0] shadow [NREG];
  logic       active;

  assign idx    = byte1[7:1];
  assign idx_ok = (int'(idx) < NREG) || (idx == RESET_IDX);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      full     <= 1'b0;
      skip     <= 1'b0;
      byte1    <= '0;
      oe       <= 1'b0;
      busy     <= 1'b0;
      we       <= 1'b0;
      err      <= 1'b0;
      reg_addr <= '0;
      reg_data <= '0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      full     <= full_n;
      skip     <= skip_n;
      byte1    <= byte1_n;
      oe       <= oe_n;
      busy     <= busy_n;
      we       <= we_n;
      err      <= err_n;
      reg_addr <= reg_addr_n;
      reg_data <= reg_data_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    full_n     = full;
    skip_n     = skip;
    byte1_n    = byte1;
    oe_n       = oe;
    busy_n     = busy;
    we_n       = 1'b0;
    err_n      = 1'b0;
    reg_addr_n = reg_addr;
    reg_data_n = reg_data;

    // START outranks everything, including an SCL edge in the same cycle
    if (start) begin
      state_n   = S_ADDR;
      bit_cnt_n = '0;
      full_n    = 1'b0;
      skip_n    = 1'b0;
      oe_n      = 1'b0;
      busy_n    = 1'b1;
    end else if (stop) begin
      if (state inside {S_ADDR, S_ACK_A, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2})
        err_n = 1'b1;
      state_n = S_IDLE;
      full_n  = 1'b0;
      skip_n  = 1'b0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (scl_rise) begin
      if (state inside {S_ADDR, S_BYTE1, S_BYTE2, S_WAIT_STOP}) begin
        if (skip) begin
          skip_n = 1'b0;
        end else begin
          shreg_n   = {shreg[6:0], sda};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) full_n = 1'b1;
        end
      end
    end else if (scl_fall) begin
      case (state)
        S_ADDR: if (full) begin
          full_n = 1'b0;
          if (shreg == DEV_ADDR) begin
            state_n = S_ACK_A;
            oe_n    = 1'b1;
          end else begin
            state_n = S_IGNORE;
          end
        end
        S_ACK_A: begin
          oe_n    = 1'b0;
          state_n = S_BYTE1;
        end
        S_BYTE1: if (full) begin
          full_n  = 1'b0;
          byte1_n = shreg;
          oe_n    = 1'b1;
          state_n = S_ACK1;
        end
        S_ACK1: begin
          oe_n    = 1'b0;
          state_n = S_BYTE2;
        end
        S_BYTE2: if (full) begin
          full_n  = 1'b0;
          oe_n    = 1'b1;
          state_n = S_ACK2;
        end
        S_ACK2: begin
          oe_n    = 1'b0;
          state_n = S_WAIT_STOP;
          if (idx_ok) begin
            we_n       = 1'b1;
            reg_addr_n = idx;
            reg_data_n = {byte1[0], shreg};
          end else begin
            err_n = 1'b1;
          end
        end
        S_WAIT_STOP: if (full) begin
          full_n = 1'b0;
          skip_n = 1'b1;
          err_n  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Shadow file; a write to RESET_IDX clears the whole file one cycle later
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      clr_q <= 1'b0;
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else begin
      clr_q <= we_n && (reg_addr_n == RESET_IDX);
      if (clr_q) begin
        for (int i = 0; i < NREG; i++) shadow[i] <= '0;
      end else if (we_n) begin
        for (int i = 0; i < NREG; i++)
          if (7'(i) == reg_addr_n) shadow[i] <= reg_data_n;
      end
    end
  end

  always_comb begin
    active = 1'b0;
    for (int i = 0; i < NREG; i++)
      if (7'(i) == ACTIVE_IDX) active = shadow[i][0];
  end

  assign bus.I2C_SDAT_OE = oe;
  assign bus.REG_WE      = we;
  assign bus.REG_ADDR    = reg_addr;
  assign bus.REG_DATA    = reg_data;
  assign bus.ACTIVE      = active;
  assign bus.ERR         = err;
  assign bus.BUSY        = busy;

endmodule

// File: doc/i2c_codec_responder.md
I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 Parameter DEV_ADDR, default 8'h34, is the write-form device address byte matched after START.
REQ-002 Parameter NREG, default 12, is the number of shadow registers, indices 0..NREG-1.
REQ-003 CLOCK  in  1  system clock; the sole clock domain.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 I2C_SCLK  in  1  bus clock from the initiator, asynchronous to CLOCK.
REQ-006 I2C_SDAT_IN  in  1  bus data as seen on the pad.
REQ-007 I2C_SDAT_OE  out  1  1 = pull SDA low (ACK); the pad is open-drain.
REQ-008 REG_WE  out  1  one-cycle pulse per completed register write.
REQ-009 REG_ADDR  out  7  register index of the last write.
REQ-010 REG_DATA  out  9  register value of the last write.
REQ-011 ACTIVE  out  1  shadow register 9, bit 0 (codec active).
REQ-012 ERR  out  1  one-cycle pulse on a protocol error.
REQ-013 BUSY  out  1  high from an accepted START until STOP.

Function
REQ-014 SCLK and SDA SHALL pass through 2-flop synchronizers, plus one history flop for edge detection; all decisions use the synchronized values.
REQ-015 START SHALL be recognised when SDA falls while SCLK is high; STOP when SDA rises while SCLK is high; each is detected in every state.
REQ-016 FSM states: IDLE, ADDR, ACK_A, BYTE1, ACK1, BYTE2, ACK2, WAIT_STOP, IGNORE.
REQ-017 Data bits SHALL be sampled on SCLK rising edges, MSB first, into an 8-bit shift register with a 3-bit bit counter.
REQ-018 In ADDR, after 8 bits: a byte equal to DEV_ADDR goes to ACK_A; any other byte, including R/W=1, goes to IGNORE with no ACK.
REQ-019 ACK SHALL be driven (I2C_SDAT_OE=1) from the SCLK falling edge after bit 8 until the SCLK falling edge after bit 9.
REQ-020 BYTE1 holds {addr[6:0], data[8]}; BYTE2 holds data[7:0].
REQ-021 At the SCLK falling edge ending ACK2: if the index is below NREG, REG_WE SHALL pulse for 1 CLOCK with REG_ADDR/REG_DATA updated in the same cycle, and the shadow register SHALL be written; FSM -> WAIT_STOP.
REQ-022 An index >= NREG SHALL still be ACKed, produce no REG_WE, and raise ERR.
REQ-023 A write to index 7'h0F SHALL produce REG_WE and reset all shadow registers to 0 on the following cycle, so ACTIVE = 0.
REQ-024 In WAIT_STOP, a further data byte SHALL be NACKed and SHALL raise ERR; FSM stays in WAIT_STOP.
REQ-025 A repeated START in any state SHALL discard partial data and enter ADDR.
REQ-026 A STOP in ADDR..ACK2 SHALL abort with no write, raise ERR, and enter IDLE.
REQ-027 A STOP in WAIT_STOP or IGNORE SHALL enter IDLE without ERR.
REQ-028 In IGNORE, I2C_SDAT_OE SHALL stay 0 until START or STOP.
REQ-029 If START and an SCLK edge would be detected in the same cycle, START SHALL win.
REQ-030 Bus-to-REG_WE latency: at most 4 CLOCK cycles after the SCLK fall, counting synchronizers.

Reset
REQ-031 On RESET low: FSM = IDLE; I2C_SDAT_OE, REG_WE, ERR and BUSY = 0; REG_ADDR/REG_DATA = 0; shadow registers = 0; synchronizer flops = 1 (bus idle).
REQ-032 Reset asserted mid-ACK SHALL release SDA immediately (asynchronously).

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, DEV_ADDR default 8'h34, RESET_IDX 7'h0F, ACTIVE_IDX 7'd9.
REQ-034 One sub-module, i2c_bus_sync, SHALL provide synchronization and START/STOP/rise/fall detection; the FSM and shadow file live in the top module.

Verification
REQ-035 Write 34/12/17 (reg 9 data 0x017 with bit0=1) -> three ACKs, REG_WE once, REG_ADDR=9, REG_DATA=0x017, ACTIVE=1.
REQ-036 Address byte 0x36 -> no ACK on bit 9, no REG_WE, BUSY=1 until STOP, then IDLE.
REQ-037 STOP after 34/0E only -> ERR pulse, no REG_WE, IDLE.
REQ-038 Repeated START after 34/0C, then 34/0C/00 -> exactly one REG_WE, REG_ADDR=6, REG_DATA=0.
REQ-039 Write reg 9 = 0x001, then 34/1E/00 -> REG_WE with REG_ADDR=0x0F, ACTIVE falls to 0 one cycle later.
REQ-040 RESET asserted while OE=1 during ACK1 -> OE=0 the same cycle; next transaction 34/08/12 completes normally.
